exec_step_controller: RTL and testbench
=======================================

// Module: exec_step_controller
// PURPOSE
//  Sequences processor execution from the 50 MHz board clock: issues one-cycle execute
//  enables at a divided rate and stalls on IN instructions until the operator presses enter.
//  Halts on HLT and latches the debounced interruption button as a pending IRQ.
//  Sits between the board pins and Processor/DataMemory; supersedes the gated-clock divider,
//  so the whole design runs on clock50 with an enable.
// PARAMETERS
//  DIV       25_000_000  clock50 cycles between execute enables in RUN (>=2)
//  DEBOUNCE  500_000     cycles a synchronized button must be stable to register (>=1)
//  OP_IN     6'h1E       opcode that waits for operator input
//  OP_HLT    6'h3F       opcode that stops execution
// PORTS
//  clock50      in   1  board clock; sole clock
//  reset        in   1  asynchronous, active-low; clears all state
//  enter        in   1  raw pushbutton, active-low (pressed = 0)
//  interruption in   1  raw pushbutton, active-low
//  opcode       in   6  opcode of the instruction the next enable will execute
//  irq_ack      in   1  processor acknowledges the pending interrupt (level, 1 cycle)
//  cpu_en       out  1  one-cycle execute enable to Processor/DataMemory
//  in_wait      out  1  high while stalled on OP_IN (drives LED)
//  halted       out  1  high in HALT
//  irq_pending  out  1  latched interrupt request
// BEHAVIOUR
//  Reset: state=RUN, divider=0, cpu_en=0, in_wait=0, halted=0, irq_pending=0,
//   debouncers = released (1).
//  Divider: counts 0..DIV-1 only in RUN; terminal count (tc) at DIV-1, then wraps to 0.
//   Cleared to 0 on every entry to RUN.
//  FSM (registered outputs, 1-cycle latency from decision):
//   RUN:  at tc: opcode==OP_HLT -> HALT, no enable; opcode==OP_IN -> WAIT_PRESS, no enable;
//         else cpu_en=1 next cycle, stay RUN.
//   WAIT_PRESS: in_wait=1. Debounced enter falling edge -> cpu_en=1 for exactly one cycle
//         (IN executes, samples switches) -> WAIT_RELEASE.
//   WAIT_RELEASE: in_wait=0. Debounced enter rising edge -> RUN. A button held across
//         instructions never issues more than one enable.
//   HALT: halted=1, no enables. Debounced interruption falling edge -> RUN.
//  IRQ: debounced interruption falling edge sets irq_pending in any state; irq_ack clears it.
//   Same-cycle set and ack -> irq_pending stays 1 (set wins).
//  Debounce: 2-FF synchronizer, then counter reloads on any change; output updates after
//   DEBOUNCE consecutive stable cycles; one-cycle edge strobes derived from output.
//  Glitches shorter than DEBOUNCE cycles produce no edge and no state change.
//  Reset mid-stall/mid-count returns to RUN immediately; a held button after reset
//   registers as a press once debounced.
//  cpu_en is never high two consecutive cycles; never high outside RUN/WAIT_PRESS exit.
// STRUCTURE
//  Shared package exec_pkg: state enum {RUN, WAIT_PRESS, WAIT_RELEASE, HALT},
//   OP_IN/OP_HLT opcode constants (shared with the processor decoder).
//  Sub-module: button_debounce (sync + stability counter + fall/rise strobes),
//   instantiated for enter and interruption.
//  Counter widths from $clog2(DIV) and $clog2(DEBOUNCE+1).
// TESTING  (DIV=4, DEBOUNCE=3)
//  1 Reset, opcode=6'h00 -> cpu_en pulses every 4th cycle, first at cycle 4 after release.
//  2 opcode=OP_IN at tc -> no pulse, in_wait=1; enter low 5 cycles -> one cpu_en ~5 cycles
//    after press (sync+debounce), in_wait=0; no further pulse until enter high >=3+2 cycles.
//  3 enter bounce 0/1 every cycle for 10 cycles while WAIT_PRESS -> no cpu_en, in_wait stays 1.
//  4 opcode=OP_HLT at tc -> halted=1, no pulses for 40 cycles; interruption low 5 cycles ->
//    irq_pending=1, halted=0, pulses resume 4 cycles later.
//  5 irq edge and irq_ack in same cycle -> irq_pending=1; ack alone next -> 0.
//  6 reset asserted in WAIT_PRESS -> all outputs 0 asynchronously; after release RUN, divider=0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execution step controller and the processor decoder:
// controller state encoding and the two opcodes the controller reacts to.
package exec_pkg;

   typedef enum logic [1:0] {
      RUN          = 2'd0,
      WAIT_PRESS   = 2'd1,
      WAIT_RELEASE = 2'd2,
      HALT         = 2'd3
   } exec_state_e;

   localparam logic [5:0] OP_IN  = 6'h1E;
   localparam logic [5:0] OP_HLT = 6'h3F;

endpackage

// File: rtl/button_debounce.sv
// Active-low pushbutton conditioner: 2-FF synchronizer, stability counter and
// one-cycle fall/rise strobes that coincide with the debounced level changing.
module button_debounce #(
   parameter int DEBOUNCE = 500_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic fall_o,
   output logic rise_o
);

   localparam int CW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          settle;

   // Released (1) is the idle level, so reset never fabricates a press.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      settle  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            settle  = 1'b1;
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign fall_o = settle & ~sync2_q;
   assign rise_o = settle &  sync2_q;

endmodule

// File: rtl/exec_step_controller.sv
// Issues one-cycle execute enables from clock50 at a divided rate, stalls on IN until
// the operator presses enter, stops on HLT and latches the interruption button as an IRQ.
module exec_step_controller
   import exec_pkg::*;
#(
   parameter int DIV      = 25_000_000,
   parameter int DEBOUNCE = 500_000
) (
   input  logic        clock50,
   input  logic        reset,
   input  logic        enter,
   input  logic        interruption,
   input  logic [5:0]  opcode,
   input  logic        irq_ack,
   output logic        cpu_en,
   output logic        in_wait,
   output logic        halted,
   output logic        irq_pending,
   output exec_state_e state_dbg
);

   localparam int DW = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   exec_state_e   state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic          cpu_en_q, cpu_en_d;
   logic          in_wait_q, in_wait_d;
   logic          halted_q, halted_d;
   logic          irq_q, irq_d;
   logic          tc;
   logic          enter_fall, enter_rise;
   logic          int_fall, int_rise_unused;

   button_debounce #(.DEBOUNCE(DEBOUNCE)) u_enter_db (
      .clk_i  (clock50),
      .rst_ni (reset),
      .btn_i  (enter),
      .fall_o (enter_fall),
      .rise_o (enter_rise)
   );

   button_debounce #(.DEBOUNCE(DEBOUNCE)) u_int_db (
      .clk_i  (clock50),
      .rst_ni (reset),
      .btn_i  (interruption),
      .fall_o (int_fall),
      .rise_o (int_rise_unused)
   );

   assign tc = (state_q == RUN) && (div_q == DIV_LAST);

   always_ff @(posedge clock50 or negedge reset) begin
      if (!reset) begin
         state_q   <= RUN;
         div_q     <= '0;
         cpu_en_q  <= 1'b0;
         in_wait_q <= 1'b0;
         halted_q  <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         cpu_en_q  <= cpu_en_d;
         in_wait_q <= in_wait_d;
         halted_q  <= halted_d;
         irq_q     <= irq_d;
      end
   end

   // The divider only advances in RUN, so every entry to RUN starts a fresh period.
   always_comb begin
      state_d = state_q;
      div_d   = '0;
      case (state_q)
         RUN: begin
            if (tc) begin
               if (opcode == OP_HLT)     state_d = HALT;
               else if (opcode == OP_IN) state_d = WAIT_PRESS;
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         WAIT_PRESS:   if (enter_fall) state_d = WAIT_RELEASE;
         WAIT_RELEASE: if (enter_rise) state_d = RUN;
         HALT:         if (int_fall)   state_d = RUN;
         default:      state_d = RUN;
      endcase
   end

   // Set wins over a same-cycle acknowledge so no interrupt is ever lost.
   always_comb begin
      cpu_en_d  = (tc && (opcode != OP_HLT) && (opcode != OP_IN)) ||
                  ((state_q == WAIT_PRESS) && enter_fall);
      in_wait_d = (state_d == WAIT_PRESS);
      halted_d  = (state_d == HALT);
      irq_d     = int_fall | (irq_q & ~irq_ack);
   end

   assign cpu_en      = cpu_en_q;
   assign in_wait     = in_wait_q;
   assign halted      = halted_q;
   assign irq_pending = irq_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_exec_step_controller.sv
// Directed-plus-random bench for exec_step_controller (DIV=4, DEBOUNCE=3) checked every
// cycle against a cycle-indexed behavioural model of buttons, divider and stall rules.
module tb_exec_step_controller;
   import exec_pkg::*;

   localparam int DIV = 4;
   localparam int DEB = 3;
   localparam int HMAX = 8191;
   localparam int M_RUN = 0, M_WP = 1, M_WR = 2, M_HALT = 3;

   logic        clock50 = 1'b0;
   logic        reset = 1'b0;
   logic        enter = 1'b1;
   logic        interruption = 1'b1;
   logic [5:0]  opcode = 6'h00;
   logic        irq_ack = 1'b0;
   logic        cpu_en, in_wait, halted, irq_pending;
   exec_state_e state_dbg;

   int checks = 0;
   int failures = 0;
   int pulses;

   // model state: mode, cycles left until the next divided decision, expected outputs
   int m_mode, m_left, k;
   bit m_en, m_irq;
   bit deb[2];
   bit hist[2][0:HMAX];

   always #10 clock50 = ~clock50;

   exec_step_controller #(.DIV(DIV), .DEBOUNCE(DEB)) dut (
      .clock50      (clock50),
      .reset        (reset),
      .enter        (enter),
      .interruption (interruption),
      .opcode       (opcode),
      .irq_ack      (irq_ack),
      .cpu_en       (cpu_en),
      .in_wait      (in_wait),
      .halted       (halted),
      .irq_pending  (irq_pending),
      .state_dbg    (state_dbg)
   );

   // raw button value seen at edge idx after two synchronizer stages; idle before reset release
   function automatic bit synced(int ch, int idx);
      int r;
      r = idx - 2;
      if (r < 1) return 1'b1;
      return hist[ch][r];
   endfunction

   function automatic logic [5:0] rand_op();
      logic [5:0] v;
      do v = 6'($urandom_range(0, 63)); while (v == OP_IN || v == OP_HLT);
      return v;
   endfunction

   task automatic model_reset();
      m_mode = M_RUN; m_left = DIV; k = 0;
      m_en = 1'b0; m_irq = 1'b0;
      deb[0] = 1'b1; deb[1] = 1'b1;
   endtask

   task automatic deb_edge(input int ch, output bit fall, output bit rise);
      bit settle;
      settle = 1'b1;
      for (int j = 0; j < DEB; j++)
         if (synced(ch, k - j) == deb[ch]) settle = 1'b0;
      fall = settle && deb[ch];
      rise = settle && !deb[ch];
      if (settle) deb[ch] = !deb[ch];
   endtask

   task automatic model_step();
      bit ef, er, ifl, ir;
      if (k < HMAX) k++;
      hist[0][k] = enter;
      hist[1][k] = interruption;
      deb_edge(0, ef, er);
      deb_edge(1, ifl, ir);
      m_en = 1'b0;
      case (m_mode)
         M_RUN: begin
            m_left--;
            if (m_left == 0) begin
               m_left = DIV;
               if (opcode == OP_HLT)     m_mode = M_HALT;
               else if (opcode == OP_IN) m_mode = M_WP;
               else                      m_en = 1'b1;
            end
         end
         M_WP:   if (ef) begin m_en = 1'b1; m_mode = M_WR; end
         M_WR:   if (er) begin m_mode = M_RUN; m_left = DIV; end
         default: if (ifl) begin m_mode = M_RUN; m_left = DIV; end
      endcase
      if (ifl)          m_irq = 1'b1;
      else if (irq_ack) m_irq = 1'b0;
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check("cpu_en", cpu_en, m_en);
      check("in_wait", in_wait, m_mode == M_WP);
      check("halted", halted, m_mode == M_HALT);
      check("irq_pending", irq_pending, m_irq);
   endtask

   task automatic tick();
      if (reset) model_step(); else model_reset();
      @(posedge clock50);
      @(negedge clock50);
      check_outputs();
   endtask

   task automatic tick_count(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         pulses += int'(cpu_en);
      end
   endtask

   task automatic wait_mode(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (m_mode != target && n < budget) begin
         tick();
         n++;
      end
      check(tag, m_mode == target, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      @(negedge clock50);
      check("reset_cpu_en", cpu_en, 1'b0);
      check("reset_in_wait", in_wait, 1'b0);
      check("reset_halted", halted, 1'b0);
      check("reset_irq", irq_pending, 1'b0);
      repeat (2) tick();

      // free run: enables on cycles 4, 8, 12 after release
      reset = 1'b1;
      pulses = 0;
      tick_count(12);
      check_int("t1_pulses", pulses, 3);
      opcode = rand_op();
      tick_count(9);

      // IN stall, one enable per press
      opcode = OP_IN;
      wait_mode(M_WP, 8, "t2_reach_wait");
      opcode = rand_op();
      pulses = 0;
      enter = 1'b0;
      tick_count(5);
      check_int("t2_one_enable", pulses, 1);
      enter = 1'b1;
      pulses = 0;
      tick_count(4);
      check_int("t2_no_enable_release", pulses, 0);
      tick_count(8);

      // button held across instructions
      opcode = OP_IN;
      wait_mode(M_WP, 8, "t2h_reach_wait");
      pulses = 0;
      enter = 1'b0;
      tick_count(30);
      check_int("t2h_held_one_enable", pulses, 1);
      enter = 1'b1;
      opcode = rand_op();
      tick_count(10);

      // bounce shorter than DEBOUNCE while stalled
      opcode = OP_IN;
      wait_mode(M_WP, 8, "t3_reach_wait");
      opcode = rand_op();
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         enter = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick();
         pulses += int'(cpu_en);
      end
      enter = 1'b1;
      tick_count(4);
      check_int("t3_bounce_no_enable", pulses, 0);
      check("t3_still_waiting", in_wait, 1'b1);
      enter = 1'b0;
      tick_count(6);
      enter = 1'b1;
      tick_count(8);

      // halt, then resume via interruption
      opcode = OP_HLT;
      wait_mode(M_HALT, 8, "t4_reach_halt");
      opcode = rand_op();
      pulses = 0;
      tick_count(40);
      check_int("t4_halt_no_enable", pulses, 0);
      interruption = 1'b0;
      tick_count(5);
      interruption = 1'b1;
      check("t4_resumed", halted, 1'b0);
      check("t4_irq_set", irq_pending, 1'b1);
      pulses = 0;
      tick_count(4);
      check_int("t4_resume_enable", pulses, 1);

      // same-cycle irq set and ack
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      interruption = 1'b0;
      repeat (4) tick();
      irq_ack = 1'b1;
      tick();
      check("t5_set_wins", irq_pending, 1'b1);
      tick();
      check("t5_ack_clears", irq_pending, 1'b0);
      irq_ack = 1'b0;
      interruption = 1'b1;
      tick_count(8);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 15))
            0, 1:    opcode = OP_IN;
            2:       opcode = OP_HLT;
            default: opcode = rand_op();
         endcase
         if ($urandom_range(0, 9) == 0)  enter = ~enter;
         if ($urandom_range(0, 19) == 0) interruption = ~interruption;
         irq_ack = ($urandom_range(0, 7) == 0);
         tick();
      end
      irq_ack = 1'b0;

      // reset in the middle of a stall, enter held through reset
      enter = 1'b1;
      interruption = 1'b1;
      tick_count(8);
      interruption = 1'b0;
      tick_count(6);
      interruption = 1'b1;
      tick_count(6);
      opcode = OP_IN;
      wait_mode(M_WP, 40, "t6_reach_wait");
      check("t6_pre_in_wait", in_wait, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("t6_async_cpu_en", cpu_en, 1'b0);
      check("t6_async_in_wait", in_wait, 1'b0);
      check("t6_async_halted", halted, 1'b0);
      check("t6_async_irq", irq_pending, 1'b0);
      enter = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      pulses = 0;
      tick_count(12);
      check_int("t6_held_press_after_reset", pulses, 1);
      enter = 1'b1;
      opcode = rand_op();
      tick_count(12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
